ram_seq_ctrl: RTL and testbench
===============================

# ram_seq_ctrl

Sequential fill/dump controller that sits directly upstream of the 64x8 single-port RAM and is that RAM's only master. It accepts a valid/ready byte stream and writes it to consecutive addresses from 0. On command it reads the stored bytes back in order and emits them as a valid/ready stream with backpressure. It absorbs the RAM's one-cycle registered-read latency in an internal skid FIFO.

## Interface
- DATA_W, 8, RAM word width
- ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W = 64
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_valid / s_ready  in / out  1  write-stream handshake
- s_data  in  DATA_W  write-stream byte
- dump_start  in  1  single-cycle dump request
- m_valid / m_ready  out / in  1  read-stream handshake
- m_data  out  DATA_W  read-stream byte
- m_last  out  1  marks the final byte of a dump
- fill_count  out  ADDR_W+1  bytes currently stored, 0..DEPTH
- busy  out  1  high in DUMP
- checksum  out  DATA_W  running sum of stored bytes (see Configuration)
- ram_data  out  DATA_W; ram_addr  out  ADDR_W; ram_we  out  1  drive the RAM
- ram_q  in  DATA_W  RAM registered read data

## Operation
- States: FILL (reset state) and DUMP.
- FILL:
  - s_ready = !full, where full = (fill_count == DEPTH).
  - On handshake: ram_we=1, ram_addr=fill_count[ADDR_W-1:0], ram_data=s_data; fill_count increments.
- FILL -> DUMP:
  - Taken on dump_start when fill_count>0, or when a write handshakes in the same cycle. That write is stored and included in the dump.
  - dump_start with fill_count==0 and no handshake is ignored.
- DUMP:
  - s_ready=0 and ram_we=0. dump_start is ignored.
  - A read of address rd_ptr issues when rd_ptr<fill_count and (fifo_occ + inflight) < 3. Then rd_ptr increments.
  - ram_q is pushed to the 3-entry FIFO on the cycle after issue.
  - m_* is driven from the FIFO head. m_last=1 when the head is element fill_count-1.
- DUMP -> FILL:
  - Taken on the m_last handshake: fill_count=0, rd_ptr=0, FIFO empty.
  - Stored data is not re-readable afterwards.
- FIFO never overflows; credit check guarantees it.
- Reset mid-dump aborts the dump: state=FILL and all counters, flags and FIFO are cleared. RAM contents are unaffected (the RAM has no reset).
- ram_we is forced 0 while rst_n is low.
- Reset values: s_ready=1 (after release), m_valid=0, m_last=0, m_data=0, fill_count=0, busy=0, checksum=0, ram_we=0, ram_addr=0, ram_data=0.

## Timing
- Write: byte accepted in cycle T is in RAM at the end of T. Sustained 1 byte/cycle.
- dump_start in cycle T:
  - busy=1 from T+1.
  - First read issued in T+1; ram_q valid in T+2; m_valid=1 from T+3.
- With m_ready held high, output is 1 byte/cycle with no bubbles after T+3.
- A DUMP of N bytes ends with busy=0 in the cycle after the m_last handshake. s_ready=1 from that cycle.
- m_data/m_last hold stable while m_valid=1 and m_ready=0.

## Configuration
- RAM_SEQ_CTRL_CHECKSUM_EN defined:
  - checksum = sum mod 2**DATA_W of all bytes accepted since the last dump completion or reset.
  - Updated on each write handshake and held through DUMP. Cleared with fill_count.
- Undefined: checksum is tied to 0 and the accumulator register is absent.

## Structure
- Shared package ram_seq_pkg: DATA_W/ADDR_W/DEPTH constants, FIFO_DEPTH=3, state enum {FILL, DUMP}.
- Sub-module ram_seq_fifo: 3-entry synchronous FIFO carrying {last, data}, with push/pop/occ. Same clock/reset.
- Top holds the FSM, counters, credit logic and checksum.

## Test plan
- Reset, then write 0x11,0x22,0x33,0x44 back-to-back -> fill_count=4, checksum=0xAA (macro on), s_ready stays 1.
- dump_start at T with m_ready=1 -> m_data 0x11..0x44 in cycles T+3..T+6, m_last only with 0x44; busy low at T+7; fill_count=0.
- Write 64 bytes 0x00..0x3F -> s_ready=0 at fill_count=64, and a 65th s_valid is not accepted. Dump -> 64 bytes in order, m_last on 0x3F.
- Dump 8 bytes with m_ready toggling 1/0 every cycle -> all 8 in order, none lost or duplicated. m_data is stable while stalled; no more than 3 reads outstanding.
- dump_start with fill_count=0 -> stays FILL, m_valid never asserts. dump_start same cycle as write of 0x5A to empty buffer -> dump emits single 0x5A with m_last=1.
- Assert rst_n low mid-dump after 2 of 5 bytes -> m_valid=0 and fill_count=0 immediately. After release, write 0x01 and dump -> emits 0x01 only.

Source files
------------

// File: rtl/ram_seq_pkg.sv
// Purpose: shared constants, FSM state and read-pipeline entry type for the ram_seq_ctrl block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Ports: none (package). Imported by ram_seq_fifo and ram_seq_ctrl.
package ram_seq_pkg;

  localparam int DATA_W     = 8;            // RAM word width
  localparam int ADDR_W     = 6;            // RAM address width
  localparam int DEPTH      = 2**ADDR_W;    // RAM words (64)
  localparam int CNT_W      = ADDR_W + 1;   // counters must reach DEPTH itself
  localparam int FIFO_DEPTH = 3;            // read skid FIFO entries

  typedef enum logic {
    FILL = 1'b0,
    DUMP = 1'b1
  } state_t;

  // One read-back element: the byte plus a flag marking the final byte of the dump.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rd_ent_t;

endpackage

// File: rtl/ram_seq_fifo.sv
// Purpose: small generic synchronous FIFO, used as the read-data skid buffer.
// Latency: a push is visible at head on the next cycle; head is read combinationally.
// Backpressure: push on a full FIFO is dropped unless a pop happens in the same cycle;
//               pop on empty is ignored. The caller is expected to never overflow it.
// Ports: clk, rst_n (async active-low), clr (synchronous flush), push/push_data,
//        pop, head (oldest entry), occ (entries held), empty.
module ram_seq_fifo
  import ram_seq_pkg::*;
#(
  parameter int WIDTH   = DATA_W + 1,
  parameter int ENTRIES = FIFO_DEPTH,
  localparam int PTR_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int OCC_W  = $clog2(ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OCC_W-1:0] occ,
  output logic             empty
);

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at ENTRIES, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (occ == '0);
  assign full    = (occ == OCC_W'(ENTRIES));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      // Storage is cleared so the head reads as zero out of reset.
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      occ <= occ + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

endmodule

// File: rtl/ram_seq_ctrl.sv
// Purpose: sequential fill/dump master for a 64x8 single-port RAM (write stream in, read stream out).
// Latency: write stored the cycle it is accepted; dump_start at T gives first m_valid at T+3, then 1 byte/cycle.
// Backpressure: s_ready drops when full or dumping; m_ready stalls are absorbed by a 3-entry skid FIFO
//               with credit-limited read issue, so output data holds stable while stalled.
// Ports: clk, rst_n (async active-low); s_valid/s_ready/s_data write stream; dump_start;
//        m_valid/m_ready/m_data/m_last read stream; fill_count, busy, checksum status;
//        ram_data/ram_addr/ram_we to the RAM, ram_q registered RAM read data.
// Config: define RAM_SEQ_CTRL_CHECKSUM_EN to build the running byte checksum; otherwise checksum is 0.
module ram_seq_ctrl
  import ram_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              dump_start,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [ADDR_W:0]   fill_count,
  output logic              busy,
  output logic [DATA_W-1:0] checksum,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W:0]   rd_ptr_q;
  logic              infl_q;        // a read was issued last cycle; its data is on ram_q now
  logic              infl_last_q;   // that read was the final element of the dump
  logic              full;
  logic              wr_fire;
  logic              rd_issue;
  logic              rd_last;
  logic              out_fire;
  logic              dump_done;
  logic [OCC_W:0]    credit_used;
  rd_ent_t           fifo_head;
  rd_ent_t           fifo_in;
  logic [OCC_W-1:0]  fifo_occ;
  logic              fifo_empty;

  assign full        = (fill_count == CNT_W'(DEPTH));
  assign rd_last     = (rd_ptr_q == fill_count - 1'b1);
  // Entries already in the FIFO plus the one read still in the RAM pipeline;
  // a new read is only issued if its data is guaranteed a FIFO slot.
  assign credit_used = {1'b0, fifo_occ} + (OCC_W + 1)'(infl_q);
  assign out_fire    = m_valid && m_ready;
  assign dump_done   = out_fire && m_last;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    s_ready  = 1'b0;
    wr_fire  = 1'b0;
    rd_issue = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    case (state_q)
      FILL: begin
        s_ready  = !full;
        wr_fire  = s_valid && !full;
        // The RAM has no reset, so never let a write through while reset is held.
        ram_we   = wr_fire && rst_n;
        ram_addr = fill_count[ADDR_W-1:0];
        if (ram_we) begin
          ram_data = s_data;
        end
        // A write landing in the same cycle makes an otherwise empty buffer dumpable.
        if (dump_start && ((fill_count != '0) || wr_fire)) begin
          state_d = DUMP;
        end
      end
      DUMP: begin
        rd_issue = (rd_ptr_q < fill_count) &&
                   (credit_used < (OCC_W + 1)'(FIFO_DEPTH));
        ram_addr = rd_ptr_q[ADDR_W-1:0];
        if (dump_done) begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and read pipeline tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count  <= '0;
      rd_ptr_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q      <= rd_issue;
      infl_last_q <= rd_issue && rd_last;
      if (dump_done) begin
        // Completion discards the stored data; the next fill starts at address 0.
        fill_count <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (wr_fire) begin
          fill_count <= fill_count + 1'b1;
        end
        if (rd_issue) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read skid FIFO: ram_q is captured the cycle after its read was issued.
  // ---------------------------------------------------------------------------
  assign fifo_in.last = infl_last_q;
  assign fifo_in.data = ram_q;

  ram_seq_fifo #(
    .WIDTH   ($bits(rd_ent_t)),
    .ENTRIES (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (dump_done),
    .push      (infl_q),
    .push_data (fifo_in),
    .pop       (out_fire),
    .head      (fifo_head),
    .occ       (fifo_occ),
    .empty     (fifo_empty)
  );

  assign busy    = (state_q == DUMP);
  assign m_valid = busy && !fifo_empty;
  assign m_last  = m_valid && fifo_head.last;
  assign m_data  = m_valid ? fifo_head.data : '0;

  // ---------------------------------------------------------------------------
  // Optional running checksum of accepted bytes
  // ---------------------------------------------------------------------------
`ifdef RAM_SEQ_CTRL_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (dump_done) begin
      sum_q <= '0;
    end else if (wr_fire) begin
      sum_q <= sum_q + s_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Purpose: self-checking bench for ram_seq_ctrl with a behavioural 64x8 registered-read RAM.
// Latency: checks the T+3 first-output and N+3 dump-length timing.
// Backpressure: exercises full buffer, toggling m_ready and reset mid-dump.
module tb_ram_seq_ctrl;
  import ram_seq_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              dump_start = 1'b0;
  logic              m_ready = 1'b0;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [ADDR_W:0]   fill_count;
  logic              busy;
  logic [DATA_W-1:0] checksum;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  logic [DATA_W-1:0] ram_mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [DATA_W:0]   exp_q [$];   // {last, data} expected on the read stream
  logic [DATA_W-1:0] wr_q  [$];   // bytes currently stored according to the model
  logic [DATA_W-1:0] cs_model = '0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;
  logic [DATA_W:0]   mon_e;

  ram_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .dump_start (dump_start),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .fill_count (fill_count),
    .busy       (busy),
    .checksum   (checksum),
    .ram_data   (ram_data),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_q      (ram_q)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one-cycle registered read, no reset.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_cs();
`ifdef RAM_SEQ_CTRL_CHECKSUM_EN
    return cs_model;
`else
    return '0;
`endif
  endfunction

  // Read-stream monitor: scoreboard pop on every handshake, stability while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
        chk("hold_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("m_data", 32'(m_data), 32'(mon_e[DATA_W-1:0]));
          chk("m_last", 32'(m_last), 32'(mon_e[DATA_W]));
          pops++;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    chk("s_ready_fill", 32'(s_ready), 1);
    chk("ram_we_fill", 32'(ram_we), 1);
    chk("ram_addr_fill", 32'(ram_addr), 32'(wr_q.size()));
    step();
    s_valid = 1'b0;
    wr_q.push_back(d);
    cs_model = cs_model + d;
  endtask

  task automatic do_dump(input bit toggle, input bit timed, input bit track_out,
                         input bit with_wr, input logic [DATA_W-1:0] wd);
    int n;
    int cyc;
    int base;
    int outst;
    if (with_wr) begin
      s_valid = 1'b1;
      s_data  = wd;
      wr_q.push_back(wd);
      cs_model = cs_model + wd;
    end
    n = wr_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), wr_q[i]});
    wr_q.delete();
    base = pops;
    dump_start = 1'b1;
    m_ready    = 1'b1;
    @(negedge clk);
    chk("busy_at_start", 32'(busy), 0);
    step();
    dump_start = 1'b0;
    s_valid    = 1'b0;
    for (cyc = 1; cyc <= 400; cyc++) begin
      if (toggle) m_ready = cyc[0];
      @(negedge clk);
      if (cyc == 1) chk("busy_t1", 32'(busy), 1);
      if (cyc <= 2) chk("m_valid_pre", 32'(m_valid), 0);
      if (cyc == 3) chk("m_valid_t3", 32'(m_valid), 1);
      if (track_out && busy) begin
        outst = int'(ram_addr) - (pops - base);
        chk("outstanding_le3", 32'(outst <= 3), 1);
      end
      if (!busy) break;
      step();
    end
    chk("dump_ends", 32'(busy), 0);
    if (timed) chk("dump_len", 32'(cyc), 32'(n + 3));
    m_ready  = 1'b0;
    cs_model = '0;
    chk("post_fill_count", 32'(fill_count), 0);
    chk("post_s_ready", 32'(s_ready), 1);
    chk("post_checksum", 32'(checksum), 32'(exp_cs()));
    chk("post_sb_empty", 32'(exp_q.size()), 0);
    chk("post_count", 32'(pops - base), 32'(n));
    step();
  endtask

  initial begin
    int base;

    // Reset state; a write attempt during reset must not reach the RAM.
    s_valid = 1'b1;
    s_data  = 8'h99;
    @(negedge clk);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_data", 32'(ram_data), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_fill_count", 32'(fill_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_checksum", 32'(checksum), 0);
    step();
    s_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("rel_s_ready", 32'(s_ready), 1);
    chk("rel_fill_count", 32'(fill_count), 0);
    step();

    // Four back-to-back writes, then a dump with m_ready high.
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    @(negedge clk);
    chk("fill4_count", 32'(fill_count), 4);
    chk("fill4_checksum", 32'(checksum), 32'(exp_cs()));
    chk("fill4_s_ready", 32'(s_ready), 1);
    step();
    do_dump(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Full buffer: 64 bytes, then a 65th offered and refused.
    for (int i = 0; i < DEPTH; i++) wr(8'(i));
    @(negedge clk);
    chk("full_count", 32'(fill_count), 64);
    chk("full_s_ready", 32'(s_ready), 0);
    chk("full_checksum", 32'(checksum), 32'(exp_cs()));
    s_valid = 1'b1;
    s_data  = 8'hEE;
    step();
    @(negedge clk);
    chk("full_no_we", 32'(ram_we), 0);
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("full_count_held", 32'(fill_count), 64);
    step();
    do_dump(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Eight bytes with m_ready toggling every cycle.
    for (int i = 0; i < 8; i++) wr(8'hA0 + 8'(i * 3));
    do_dump(1'b1, 1'b0, 1'b1, 1'b0, '0);

    // dump_start on an empty buffer is ignored.
    dump_start = 1'b1;
    m_ready    = 1'b1;
    step();
    dump_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("empty_busy", 32'(busy), 0);
      chk("empty_m_valid", 32'(m_valid), 0);
      step();
    end
    m_ready = 1'b0;

    // dump_start together with the first write: single byte dump.
    do_dump(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);

    // Reset in the middle of a five byte dump, after two bytes left.
    for (int i = 0; i < 5; i++) wr(8'h61 + 8'(i));
    for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), wr_q[i]});
    wr_q.delete();
    base = pops;
    dump_start = 1'b1;
    m_ready    = 1'b1;
    step();
    dump_start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_valid", 32'(m_valid), 0);
    chk("mid_rst_fill_count", 32'(fill_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_popped", 32'(pops - base), 2);
    exp_q.delete();
    cs_model = '0;
    m_ready  = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_s_ready", 32'(s_ready), 1);
    step();
    wr(8'h01);
    do_dump(1'b0, 1'b1, 1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
